// File: rtl/pulse_train_if.sv
// Control and status bundle for the pulse_train burst generator.
interface pulse_train_if #(
    parameter int PULSE_COUNT = 4
) ();
    localparam int PSW = $clog2(PULSE_COUNT + 1);

    logic           tick_in;
    logic           start;
    logic           abort;
    logic           pulse;
    logic           busy;
    logic           done;
    logic [PSW-1:0] pulses_sent;

    modport master (
        output tick_in, start, abort,
        input  pulse, busy, done, pulses_sent
    );

    modport slave (
        input  tick_in, start, abort,
        output pulse, busy, done, pulses_sent
    );
endinterface

// File: rtl/pulse_train.sv
// Burst generator timed in divided-tick units: an initial delay, then
// PULSE_COUNT high/low pulses, with start/busy/done control and abort.
module pulse_train #(
    parameter int DELAY_TICKS = 8,
    parameter int HIGH_TICKS  = 2,
    parameter int LOW_TICKS   = 3,
    parameter int PULSE_COUNT = 4
) (
    input logic         clock,
    input logic         reset,
    pulse_train_if.slave bus
);
    localparam int MAX_DH = (DELAY_TICKS > HIGH_TICKS) ? DELAY_TICKS : HIGH_TICKS;
    localparam int MAX_T  = (MAX_DH > LOW_TICKS) ? MAX_DH : LOW_TICKS;
    localparam int CW     = $clog2(MAX_T + 1);
    localparam int PSW    = $clog2(PULSE_COUNT + 1);

    // Counter value on which the closing edge of each phase lands.
    localparam logic [CW-1:0]  D_LAST = CW'((DELAY_TICKS > 0) ? DELAY_TICKS - 1 : 0);
    localparam logic [CW-1:0]  H_LAST = CW'(HIGH_TICKS - 1);
    localparam logic [CW-1:0]  L_LAST = CW'(LOW_TICKS - 1);
    localparam logic [PSW-1:0] P_LAST = PSW'(PULSE_COUNT - 1);

    typedef enum logic [2:0] {IDLE, DELAY, HIGH, LOW, DONE} state_t;

    state_t         state, next_state;
    logic           tick_q;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  last;
    logic [PSW-1:0] sent;
    logic           pulse_q, busy_q, done_q;
    logic           tick_edge, in_phase, phase_end;

    assign tick_edge = bus.tick_in & ~tick_q;
    // Edges are counted only once the state register is in a timed phase,
    // so an edge coinciding with start acceptance is dropped.
    assign in_phase  = (state == DELAY) || (state == HIGH) || (state == LOW);
    assign phase_end = in_phase && tick_edge && (cnt == last);

    // Select the terminal count of the current phase.
    always_comb begin
        last = L_LAST;
        case (state)
            DELAY:   last = D_LAST;
            HIGH:    last = H_LAST;
            default: last = L_LAST;
        endcase
    end

    // Next-state logic; abort outranks a phase end landing in the same clock.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (bus.start && !bus.abort)
                       next_state = (DELAY_TICKS == 0) ? HIGH : DELAY;
            DELAY: if (bus.abort)      next_state = IDLE;
                   else if (phase_end) next_state = HIGH;
            HIGH:  if (bus.abort)      next_state = IDLE;
                   else if (phase_end) next_state = (sent == P_LAST) ? DONE : LOW;
            LOW:   if (bus.abort)      next_state = IDLE;
                   else if (phase_end) next_state = HIGH;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Tick sampling, phase counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_q  <= 1'b0;
            cnt     <= '0;
            sent    <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tick_q <= bus.tick_in;

            if (next_state != state)       cnt <= '0;
            else if (in_phase && tick_edge) cnt <= cnt + CW'(1);

            pulse_q <= (next_state == HIGH);
            done_q  <= (next_state == DONE);

            // Leaving IDLE opens a burst; any return to IDLE (done or abort) closes it.
            if (state == IDLE && next_state != IDLE) begin
                busy_q <= 1'b1;
                sent   <= '0;
            end else if (next_state == IDLE) begin
                busy_q <= 1'b0;
            end

            if (state == HIGH && phase_end && !bus.abort)
                sent <= sent + PSW'(1);
        end
    end

    assign bus.pulse       = pulse_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pulses_sent = sent;
endmodule

// File: tb/tb_pulse_train.sv
// Scoreboard bench for pulse_train: two instances (default timing and a
// zero-delay single-pulse variant) share one randomized stimulus stream.
module tb_pulse_train;
    localparam int D0 = 8, H0 = 2, L0 = 3, P0 = 4;
    localparam int D1 = 0, H1 = 1, L1 = 3, P1 = 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tick  = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    always #5 clock = ~clock;

    pulse_train_if #(.PULSE_COUNT(P0)) bus0 ();
    pulse_train_if #(.PULSE_COUNT(P1)) bus1 ();

    assign bus0.tick_in = tick;
    assign bus0.start   = start;
    assign bus0.abort   = abort;
    assign bus1.tick_in = tick;
    assign bus1.start   = start;
    assign bus1.abort   = abort;

    pulse_train #(.DELAY_TICKS(D0), .HIGH_TICKS(H0), .LOW_TICKS(L0), .PULSE_COUNT(P0))
        dut0 (.clock(clock), .reset(reset), .bus(bus0));
    pulse_train #(.DELAY_TICKS(D1), .HIGH_TICKS(H1), .LOW_TICKS(L1), .PULSE_COUNT(P1))
        dut1 (.clock(clock), .reset(reset), .bus(bus1));

    typedef struct {
        bit p;
        bit b;
        bit d;
        int s;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: a burst is a timeline indexed by edges counted since
    // acceptance; the output at any point follows from plain arithmetic.
    int pd[2] = '{D0, D1};
    int ph[2] = '{H0, H1};
    int pl[2] = '{L0, L1};
    int pp[2] = '{P0, P1};
    bit act[2];
    bit ind[2];
    bit tp[2];
    int n[2];
    int snt[2];

    function automatic bit in_high(int i, int nn);
        int m, per;
        if (nn < pd[i]) return 1'b0;
        m   = nn - pd[i];
        per = ph[i] + pl[i];
        return ((m / per) < pp[i]) && ((m % per) < ph[i]);
    endfunction

    function automatic int sent_of(int i, int nn);
        int m, per, k;
        if (nn < pd[i]) return 0;
        m   = nn - pd[i];
        per = ph[i] + pl[i];
        k   = (m / per) + (((m % per) >= ph[i]) ? 1 : 0);
        return (k > pp[i]) ? pp[i] : k;
    endfunction

    function automatic int total(int i);
        return pd[i] + pp[i] * ph[i] + (pp[i] - 1) * pl[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; ind[i] = 0; tp[i] = 0; n[i] = 0; snt[i] = 0;
        end
    endtask

    function automatic exp_t model_step(int i);
        exp_t e;
        bit   edg;
        e   = '{p: 1'b0, b: 1'b0, d: 1'b0, s: 0};
        edg = tick & ~tp[i];
        tp[i] = tick;
        if (act[i]) begin
            if (abort) begin
                act[i] = 0;
            end else begin
                if (edg) n[i]++;
                snt[i] = sent_of(i, n[i]);
                if (n[i] == total(i)) begin
                    act[i] = 0;
                    ind[i] = 1;
                    e.d    = 1'b1;
                    e.b    = 1'b1;
                end else begin
                    e.p = in_high(i, n[i]);
                    e.b = 1'b1;
                end
            end
        end else if (ind[i]) begin
            ind[i] = 0;
        end else if (start && !abort) begin
            act[i] = 1;
            n[i]   = 0;
            snt[i] = 0;
            e.b    = 1'b1;
            e.p    = in_high(i, 0);
        end
        e.s = snt[i];
        return e;
    endfunction

    // Predict the outputs produced by this clock edge.
    always @(posedge clock) begin
        if (reset) begin
            model_reset();
            q0.push_back('{p: 1'b0, b: 1'b0, d: 1'b0, s: 0});
            q1.push_back('{p: 1'b0, b: 1'b0, d: 1'b0, s: 0});
        end else begin
            q0.push_back(model_step(0));
            q1.push_back(model_step(1));
        end
    end

    task automatic check(string name, exp_t e, bit p, bit b, bit d, int s);
        vectors++;
        if (p !== e.p || b !== e.b || d !== e.d || s != e.s) begin
            miscompares++;
            $display("FAIL %s t=%0t got pulse=%b busy=%b done=%b sent=%0d want pulse=%b busy=%b done=%b sent=%0d",
                     name, $time, p, b, d, s, e.p, e.b, e.d, e.s);
        end
    endtask

    // Monitor: compare on the falling edge, away from the active edge.
    always @(negedge clock) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("dut0", e, bus0.pulse, bus0.busy, bus0.done, int'(bus0.pulses_sent));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("dut1", e, bus1.pulse, bus1.busy, bus1.done, int'(bus1.pulses_sent));
        end
    end

    // Tick source: 0 random, 1 divide-by-4, 2 held high, 3 held low.
    int tmode = 3;
    int cyc   = 0;

    task automatic step(bit s, bit a);
        @(posedge clock);
        #1;
        start = s;
        abort = a;
        case (tmode)
            0: tick = ($urandom % 3 == 0);
            1: tick = (cyc % 4 == 0);
            2: tick = 1'b1;
            default: tick = 1'b0;
        endcase
        cyc++;
    endtask

    task automatic timeout(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s wait expired", name);
    endtask

    initial begin
        exp_t z;
        bit   hit;
        z = '{p: 1'b0, b: 1'b0, d: 1'b0, s: 0};

        repeat (3) step(0, 0);
        reset = 1'b0;

        // Full default burst on a divide-by-4 tick, single-cycle start.
        tmode = 1;
        step(1, 0);
        repeat (130) step(0, 0);

        // start held across several bursts with random ticks.
        tmode = 0;
        repeat (300) step(1, 0);
        repeat (100) step(0, 0);

        // abort inside the third high phase.
        tmode = 1;
        step(1, 0);
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            step(0, 0);
            hit = act[0] && snt[0] == 2 && in_high(0, n[0]);
        end
        if (!hit) timeout("abort_wait");
        step(0, 0);
        step(0, 1);
        repeat (20) step(0, 0);

        // tick held high for 50 clocks during the delay counts once.
        tmode = 3;
        step(1, 0);
        repeat (2) step(0, 0);
        tmode = 2;
        repeat (50) step(0, 0);
        tmode = 1;
        repeat (130) step(0, 0);

        // Asynchronous reset in a low phase, then a fresh burst.
        step(1, 0);
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            step(0, 0);
            hit = act[0] && snt[0] >= 1 && !in_high(0, n[0]);
        end
        if (!hit) timeout("low_wait");
        #1;
        reset = 1'b1;
        q0.delete();
        q1.delete();
        model_reset();
        #1;
        check("async_rst0", z, bus0.pulse, bus0.busy, bus0.done, int'(bus0.pulses_sent));
        check("async_rst1", z, bus1.pulse, bus1.busy, bus1.done, int'(bus1.pulses_sent));
        repeat (2) step(0, 0);
        reset = 1'b0;
        step(1, 0);
        repeat (130) step(0, 0);

        // Random starts, aborts and ticks.
        tmode = 0;
        repeat (3000) step(($urandom % 8) == 0, ($urandom % 40) == 0);
        repeat (5) step(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pulse_train.md
Name: pulse_train

Overview:
Programmable pulse-train sequencer that sits directly downstream of divide_by_n. It consumes the divided tick, counts time in tick units, and emits PULSE_COUNT pulses after an initial delay. It generalises single-shot pulse timing into a start/busy/done-controlled burst generator. A typical use is strobing external parts at a slow rate.

Parameters:
DELAY_TICKS, 8, tick rising edges from start acceptance to first pulse high; 0 allowed
HIGH_TICKS, 2, tick rising edges per pulse-high phase; must be >= 1
LOW_TICKS, 3, tick rising edges per inter-pulse low phase; must be >= 1
PULSE_COUNT, 4, pulses per burst; must be >= 1

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
tick_in  in  1  divided clock from divide_by_n, synchronous to clock
start  in  1  single-cycle or level request to begin a burst
abort  in  1  synchronous cancel of a running burst
pulse  out  1  registered pulse-train output
busy  out  1  high from start acceptance until the burst ends
done  out  1  one-clock strobe at normal burst completion
pulses_sent  out  $clog2(PULSE_COUNT+1)  completed high phases in the current or last burst

Behaviour:
- Reset, async on assertion: state=IDLE, tick_q=0, tick counter=0, pulses_sent=0, pulse=0, busy=0, done=0.
- Edge detect: tick_edge = tick_in & ~tick_q, with tick_q registered each clock. tick_in held high counts once. Edges count only while the state register already holds DELAY, HIGH or LOW. An edge in the same cycle as start acceptance is ignored.
- Tick counter width is $clog2(max(DELAY_TICKS,HIGH_TICKS,LOW_TICKS)+1). It clears on every state entry and increments on tick_edge. A phase ends on the clock where tick_edge occurs with counter == limit-1.
- IDLE: when start=1 the block goes to DELAY, or to HIGH if DELAY_TICKS==0. On that clock busy<=1 and pulses_sent<=0.
- DELAY: leave after DELAY_TICKS edges -> HIGH, pulse<=1.
- HIGH: leave after HIGH_TICKS edges and pulses_sent<=pulses_sent+1.
  - If this was pulse PULSE_COUNT -> DONE, pulse<=0.
  - Otherwise -> LOW, pulse<=0.
- LOW: leave after LOW_TICKS edges -> HIGH, pulse<=1.
- DONE: lasts exactly one clock with done=1. In that clock busy<=0, then the block returns to IDLE. A start seen during the DONE clock is ignored; the earliest restart is the next clock.
- start while busy (DELAY, HIGH, LOW or DONE) is ignored. It is not queued.
- abort=1 in DELAY, HIGH or LOW: next clock state=IDLE, pulse=0, busy=0, done stays 0, pulses_sent holds its value. abort has priority over a simultaneous phase end. abort in IDLE or DONE has no effect. abort and start together in IDLE: abort wins and nothing starts.
- Outputs are all flops; no combinational path from inputs to outputs.
- Burst length in edges = DELAY_TICKS + PULSE_COUNT*HIGH_TICKS + (PULSE_COUNT-1)*LOW_TICKS. Defaults give 25.
- Reset asserted mid-burst: all outputs go to their reset values immediately, with no done strobe.

Test Plan:
1. Defaults; tick_in from divide_by_n N=4 (rising edge every 4 clocks); start pulse for 1 clock.
   -> busy=1 next clock; pulse rises on the 8th counted edge.
   -> 4 pulses of 2 edges high and 3 edges low (8 and 12 clocks).
   -> done=1 for exactly one clock, on the clock after the 25th edge; pulses_sent=4; busy=0 afterwards.
2. DELAY_TICKS=0, PULSE_COUNT=1, HIGH_TICKS=1; start.
   -> pulse=1 on the clock after acceptance; high for 1 edge; then done; pulses_sent=1.
3. start held high for the whole burst.
   -> exactly one burst runs; a new burst starts on the first clock after done.
4. abort during the 3rd HIGH phase (defaults).
   -> next clock pulse=0, busy=0, done never asserts, pulses_sent=2.
5. tick_in held high for 50 clocks during DELAY.
   -> counts as 1 edge only; counter=1.
6. Async reset mid-LOW phase with no clock edge.
   -> pulse, busy, done, pulses_sent=0 immediately; after release, start begins a fresh burst with full DELAY.
